// File: rtl/blockram_arbiter_pkg.sv
// Shared types and defaults for the BlockRam arbiter: FSM states, port ids, address/data widths.
package blockram_arbiter_pkg;

  localparam int unsigned ARB_AW = 8;
  localparam int unsigned ARB_DW = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARM    = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } stateT;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } portT;

endpackage

// File: rtl/blockram_arbiter_pick.sv
// Combinational grant selection for the BlockRam arbiter.
// Policy: fixed A-over-B by default; round-robin when BRAM_ARB_RR_EN is defined.
module blockram_arbiter_pick
  import blockram_arbiter_pkg::*;
(
  input  logic ReqA,
  input  logic ReqB,
  input  logic MaskEn,
  input  portT MaskPort,
  input  portT LastWinner,
  output logic GrantValid_c,
  output portT GrantPort_c
);

  logic reqAEff;
  logic reqBEff;

  // The port just served cannot win the arbitration made in its own DONE cycle.
  assign reqAEff      = ReqA && !(MaskEn && (MaskPort == PORT_A));
  assign reqBEff      = ReqB && !(MaskEn && (MaskPort == PORT_B));
  assign GrantValid_c = reqAEff || reqBEff;

`ifdef BRAM_ARB_RR_EN
  // On contention the port that did not win last time goes first.
  assign GrantPort_c = (reqAEff && reqBEff) ? ((LastWinner == PORT_A) ? PORT_B : PORT_A)
                                            : (reqAEff ? PORT_A : PORT_B);
`else
  logic unusedLastWinner;
  assign unusedLastWinner = (LastWinner == PORT_B);
  assign GrantPort_c      = reqAEff ? PORT_A : PORT_B;
`endif

endmodule

// File: rtl/blockram_arbiter.sv
// Shares one BlockRam (registered En/Wr) between host port A and engine port B.
// Contention policy selected by BRAM_ARB_RR_EN inside blockram_arbiter_pick (fixed A-first when undefined).
module blockram_arbiter
  import blockram_arbiter_pkg::*;
#(
  parameter int unsigned AW = ARB_AW,
  parameter int unsigned DW = ARB_DW
) (
  input  logic          Clk,
  input  logic          ResetN,
  input  logic          ReqA,
  input  logic          WrA,
  input  logic [AW-1:0] AddrA,
  input  logic [DW-1:0] DataWrA,
  output logic          AckA,
  output logic [DW-1:0] DataRdA,
  input  logic          ReqB,
  input  logic          WrB,
  input  logic [AW-1:0] AddrB,
  input  logic [DW-1:0] DataWrB,
  output logic          AckB,
  output logic [DW-1:0] DataRdB,
  output logic [AW-1:0] RamAddr,
  output logic [DW-1:0] RamDataWr,
  output logic          RamEn,
  output logic          RamWr,
  input  logic [DW-1:0] RamDataRd
);

  stateT state, stateNext;
  portT  grant, grantNext, lastWinner, lastWinnerNext, pickPort;
  logic  grantWr, grantWrNext;
  logic  pickValid, maskEn, startGrant;
  logic  ramEnNext, ramWrNext, ackANext, ackBNext, loadRdA, loadRdB;
  logic [AW-1:0] ramAddrNext;
  logic [DW-1:0] ramDataWrNext;

  blockram_arbiter_pick uPick (
    .ReqA         (ReqA),
    .ReqB         (ReqB),
    .MaskEn       (maskEn),
    .MaskPort     (grant),
    .LastWinner   (lastWinner),
    .GrantValid_c (pickValid),
    .GrantPort_c  (pickPort)
  );

  // Next state and next registered outputs; En/Wr are issued on entry to ARM.
  always_comb begin
    stateNext      = state;
    grantNext      = grant;
    grantWrNext    = grantWr;
    lastWinnerNext = lastWinner;
    maskEn         = 1'b0;
    startGrant     = 1'b0;
    ramEnNext      = 1'b0;
    ramWrNext      = 1'b0;
    ramAddrNext    = RamAddr;
    ramDataWrNext  = RamDataWr;
    ackANext       = 1'b0;
    ackBNext       = 1'b0;
    loadRdA        = 1'b0;
    loadRdB        = 1'b0;
    case (state)
      IDLE:   startGrant = pickValid;
      ARM:    stateNext  = ACCESS;
      ACCESS: stateNext  = DONE;
      DONE: begin
        maskEn     = 1'b1;
        ackANext   = (grant == PORT_A);
        ackBNext   = (grant == PORT_B);
        loadRdA    = ackANext && !grantWr;
        loadRdB    = ackBNext && !grantWr;
        startGrant = pickValid;
        stateNext  = IDLE;
      end
      default: stateNext = IDLE;
    endcase
    if (startGrant) begin
      stateNext      = ARM;
      grantNext      = pickPort;
      lastWinnerNext = pickPort;
      ramEnNext      = 1'b1;
      if (pickPort == PORT_A) begin
        ramWrNext     = WrA;
        ramAddrNext   = AddrA;
        ramDataWrNext = DataWrA;
      end else begin
        ramWrNext     = WrB;
        ramAddrNext   = AddrB;
        ramDataWrNext = DataWrB;
      end
      grantWrNext = ramWrNext;
    end
  end

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state      <= IDLE;
      grant      <= PORT_A;
      lastWinner <= PORT_B;
      grantWr    <= 1'b0;
      RamEn      <= 1'b0;
      RamWr      <= 1'b0;
      RamAddr    <= '0;
      RamDataWr  <= '0;
      AckA       <= 1'b0;
      AckB       <= 1'b0;
      DataRdA    <= '0;
      DataRdB    <= '0;
    end else begin
      state      <= stateNext;
      grant      <= grantNext;
      lastWinner <= lastWinnerNext;
      grantWr    <= grantWrNext;
      RamEn      <= ramEnNext;
      RamWr      <= ramWrNext;
      RamAddr    <= ramAddrNext;
      RamDataWr  <= ramDataWrNext;
      AckA       <= ackANext;
      AckB       <= ackBNext;
      if (loadRdA) DataRdA <= RamDataRd;
      if (loadRdB) DataRdB <= RamDataRd;
    end
  end

endmodule
